// File: rtl/cr_huf_comp_lut_bank_ctl_pkg.sv
// Shared types for the Huffman LUT bank controller.
//  e_lut_bank_state   : per-bank lifecycle FREE -> FILLING -> READY -> FREE
//  s_lut_bank_q_entry : order-queue entry {bank, seq_id}, sized for up to 8 banks
//  ERR_*              : bit positions inside err_flags
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_comp_lut_bank_ctl_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } e_lut_bank_state;

  localparam int LUT_BANK_W_MAX = 3;
  localparam int LUT_SEQID_W    = `CREOLE_HC_SEQID_WIDTH;

  typedef struct packed {
    logic [LUT_BANK_W_MAX-1:0] bank;
    logic [LUT_SEQID_W-1:0]    seq_id;
  } s_lut_bank_q_entry;

  localparam int ERR_W            = 3;
  localparam int ERR_BAD_WR_DONE  = 0;
  localparam int ERR_ACK_NO_VLD   = 1;
  localparam int ERR_MULTI_RD_VLD = 2;

endpackage

// File: rtl/cr_huf_comp_lut_bank_q.sv
// Small register FIFO holding READY banks in completion order.
//  push/push_data : enqueue (caller guarantees no overflow)
//  pop            : dequeue head (caller guarantees non-empty)
//  head/empty     : head entry straight from registers, empty flag
module cr_huf_comp_lut_bank_q #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/cr_huf_comp_lut_bank_ctl.sv
// N-bank ping-pong controller for Huffman code LUTs.
//  wr_alloc_*   : round-robin allocation of FREE banks to the table writer
//  wr_done_*    : writer completion, queues bank + seq id in completion order
//  rd_*         : oldest READY bank for the symbol assembler, released by rd_ack
//  bank_rd_*    : per-bank read data, muxed onto registered rd_data_vld/rd_data
//  err_flags    : sticky [0] bad wr_done, [1] ack w/o vld, [2] multi bank_rd_vld
// Optional: CR_HUF_COMP_LUT_BANK_STATS_EN adds saturating stat_alloc_cnt and
// stat_full_cyc counters.
module cr_huf_comp_lut_bank_ctl
  import cr_huf_comp_lut_bank_ctl_pkg::*;
#(
  parameter  int N_BANKS = 2,
  parameter  int DATA_W  = 64,
  parameter  int SEQID_W = LUT_SEQID_W,
  localparam int BANK_W  = $clog2(N_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_alloc_req,
  output logic                      wr_alloc_gnt,
  output logic [BANK_W-1:0]         wr_alloc_bank,
  input  logic                      wr_done,
  input  logic [BANK_W-1:0]         wr_done_bank,
  input  logic [SEQID_W-1:0]        wr_done_seq_id,
  output logic                      lut_full,
  output logic                      rd_bank_vld,
  output logic [BANK_W-1:0]         rd_bank,
  output logic [SEQID_W-1:0]        rd_seq_id,
  input  logic                      rd_ack,
  input  logic [N_BANKS-1:0]        bank_rd_vld,
  input  logic [N_BANKS*DATA_W-1:0] bank_rd_data,
  output logic                      rd_data_vld,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ERR_W-1:0]          err_flags
`ifdef CR_HUF_COMP_LUT_BANK_STATS_EN
  ,
  output logic [31:0]               stat_alloc_cnt,
  output logic [31:0]               stat_full_cyc
`endif
);

  e_lut_bank_state   st_q [N_BANKS];
  e_lut_bank_state   st_d [N_BANKS];
  logic [BANK_W-1:0] rr_q, rr_d;
  logic [N_BANKS-1:0] free_vec;
  logic              found;
  logic [BANK_W-1:0] alloc_bank;
  logic              done_ok, ack_ok, q_empty, multi_vld;
  s_lut_bank_q_entry push_ent, head_ent;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              rd_data_vld_q, rd_data_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    for (int i = 0; i < N_BANKS; i++) free_vec[i] = (st_q[i] == FREE);
  end

  // First FREE bank at or after the rr pointer, wrapping.
  always_comb begin
    int j;
    j          = 0;
    found      = 1'b0;
    alloc_bank = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_BANKS) j = j - N_BANKS;
      if (!found && free_vec[j]) begin
        found      = 1'b1;
        alloc_bank = BANK_W'(j);
      end
    end
  end

  assign wr_alloc_gnt  = wr_alloc_req & found;
  assign wr_alloc_bank = wr_alloc_gnt ? alloc_bank : '0;
  assign lut_full      = ~|free_vec;

  assign done_ok = wr_done && (int'(wr_done_bank) < N_BANKS) && (st_q[wr_done_bank] == FILLING);
  // Ack is judged against the registered queue state, so a same-cycle
  // wr_done into an empty queue cannot make it legal.
  assign ack_ok  = rd_ack & ~q_empty;

  always_comb begin
    push_ent        = '0;
    push_ent.bank   = LUT_BANK_W_MAX'(wr_done_bank);
    push_ent.seq_id = LUT_SEQID_W'(wr_done_seq_id);
  end

  cr_huf_comp_lut_bank_q #(
    .DEPTH (N_BANKS),
    .W     ($bits(s_lut_bank_q_entry))
  ) u_order_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (done_ok),
    .push_data (push_ent),
    .pop       (ack_ok),
    .head      (head_ent),
    .empty     (q_empty)
  );

  assign rd_bank_vld = ~q_empty;
  assign rd_bank     = q_empty ? '0 : BANK_W'(head_ent.bank);
  assign rd_seq_id   = q_empty ? '0 : SEQID_W'(head_ent.seq_id);

  // Granted, completed and released banks are always distinct (FREE,
  // FILLING, READY respectively), so the three updates never collide.
  always_comb begin
    st_d = st_q;
    if (wr_alloc_gnt) st_d[alloc_bank] = FILLING;
    if (done_ok)      st_d[wr_done_bank] = READY;
    if (ack_ok)       st_d[rd_bank] = FREE;
    rr_d = rr_q;
    if (wr_alloc_gnt)
      rr_d = (alloc_bank == BANK_W'(N_BANKS - 1)) ? '0 : alloc_bank + BANK_W'(1);
  end

  // Lowest asserted index wins; loop runs high-to-low so it overwrites last.
  always_comb begin
    rd_data_vld_d = |bank_rd_vld;
    rd_data_d     = '0;
    for (int i = N_BANKS - 1; i >= 0; i--)
      if (bank_rd_vld[i]) rd_data_d = bank_rd_data[i*DATA_W +: DATA_W];
    multi_vld = (bank_rd_vld & (bank_rd_vld - N_BANKS'(1))) != '0;
  end

  always_comb begin
    err_d                   = err_q;
    err_d[ERR_BAD_WR_DONE]  = err_q[ERR_BAD_WR_DONE]  | (wr_done & ~done_ok);
    err_d[ERR_ACK_NO_VLD]   = err_q[ERR_ACK_NO_VLD]   | (rd_ack & q_empty);
    err_d[ERR_MULTI_RD_VLD] = err_q[ERR_MULTI_RD_VLD] | multi_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BANKS; i++) st_q[i] <= FREE;
      rr_q          <= '0;
      err_q         <= '0;
      rd_data_vld_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      st_q          <= st_d;
      rr_q          <= rr_d;
      err_q         <= err_d;
      rd_data_vld_q <= rd_data_vld_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign err_flags   = err_q;
  assign rd_data_vld = rd_data_vld_q;
  assign rd_data     = rd_data_q;

`ifdef CR_HUF_COMP_LUT_BANK_STATS_EN
  logic [31:0] alloc_cnt_q, alloc_cnt_d, full_cyc_q, full_cyc_d;

  always_comb begin
    alloc_cnt_d = alloc_cnt_q;
    full_cyc_d  = full_cyc_q;
    if (wr_alloc_gnt && (alloc_cnt_q != '1))           alloc_cnt_d = alloc_cnt_q + 32'd1;
    if (wr_alloc_req && lut_full && (full_cyc_q != '1)) full_cyc_d  = full_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_cnt_q <= '0;
      full_cyc_q  <= '0;
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      full_cyc_q  <= full_cyc_d;
    end
  end

  assign stat_alloc_cnt = alloc_cnt_q;
  assign stat_full_cyc  = full_cyc_q;
`endif

endmodule
